// File: rtl/debug_apb_pkg.sv
// debug_apb_pkg: FSM state codes, default widths and constants for the debug APB arbiter
package debug_apb_pkg;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam int ADDR_W_DEF  = 5;
  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 15;
  // fill bit for the read result of a timed-out command (all ones)
  localparam logic ERR_FILL = 1'b1;
endpackage

// File: rtl/debug_rr_grant2.sv
// debug_rr_grant2: two-way round-robin grant with its own last_grant register
//   elig       eligible requester mask
//   strobe     arbitration slot; last_grant takes the winner when something is eligible
//   gnt/any    winning index / at least one eligible
//   last_grant most recently granted index, resets to 1 so requester 0 wins first
module debug_rr_grant2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] elig,
  input  logic       strobe,
  output logic       gnt,
  output logic       any,
  output logic       last_grant
);
  assign any = |elig;
  assign gnt = &elig ? ~last_grant : elig[1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_grant <= 1'b1;
    else if (strobe && any) last_grant <= gnt;
endmodule

// File: rtl/debug_apb_arbiter.sv
// debug_apb_arbiter: round-robin two-requester APB master in front of the debugger APB slave
//   REQn/WRITEn/ADDRn/WDATAn  requester commands, held stable until ACKn
//   ACKn/ERRn/RDATAn          completion pulse, error flag, read result
//   PSEL..PWDATA, PRDATA/PREADY  APB master side
//   APB_ARB_TIMEOUT_EN: abort ACCESS after TIMEOUT_CYCLES stalled cycles with ERR
import debug_apb_pkg::*;
module debug_apb_arbiter #(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              REQ0,
  input  logic              REQ1,
  input  logic              WRITE0,
  input  logic              WRITE1,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] WDATA0,
  input  logic [DATA_W-1:0] WDATA1,
  output logic              ACK0,
  output logic              ACK1,
  output logic              ERR0,
  output logic              ERR1,
  output logic [DATA_W-1:0] RDATA0,
  output logic [DATA_W-1:0] RDATA1,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be 1..255");
  end
  logic [1:0] state;
  logic [1:0] elig;
  logic gnt, any, owner, fin, to;
  logic [DATA_W-1:0] rd;
  // a requester whose ACK is showing is excluded so a held REQ is not reissued
  assign elig = {REQ1 & ~ACK1, REQ0 & ~ACK0};
  // the owner of the transfer in flight is simply the last winner
  debug_rr_grant2 u_grant (
    .clk(PCLK), .rst_n(PRESETn), .elig(elig), .strobe(state == ST_IDLE),
    .gnt(gnt), .any(any), .last_grant(owner)
  );
`ifdef APB_ARB_TIMEOUT_EN
  logic [7:0] cnt;
  assign to = state == ST_ACCESS && !PREADY && cnt == 8'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) cnt <= '0;
    else if (state == ST_SETUP) cnt <= '0;
    else if (state == ST_ACCESS && !PREADY) cnt <= cnt + 8'd1;
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) {ERR1, ERR0} <= 2'b00;
    else {ERR1, ERR0} <= {to & owner, to & ~owner};
`else
  assign to = 1'b0;
  assign ERR0 = 1'b0;
  assign ERR1 = 1'b0;
`endif
  assign fin = state == ST_ACCESS && (PREADY || to);
  // PREADY wins over an expiry in the same cycle
  assign rd = PREADY ? PRDATA : {DATA_W{ERR_FILL}};
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      state   <= ST_IDLE;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
      ACK0    <= 1'b0;
      ACK1    <= 1'b0;
      RDATA0  <= '0;
      RDATA1  <= '0;
    end else begin
      ACK0 <= fin & ~owner;
      ACK1 <= fin & owner;
      if (fin && !PWRITE && !owner) RDATA0 <= rd;
      if (fin && !PWRITE && owner) RDATA1 <= rd;
      if (state == ST_IDLE && any) begin
        state  <= ST_SETUP;
        PSEL   <= 1'b1;
        PWRITE <= gnt ? WRITE1 : WRITE0;
        PADDR  <= gnt ? ADDR1 : ADDR0;
        PWDATA <= gnt ? WDATA1 : WDATA0;
      end else if (state == ST_SETUP) begin
        state   <= ST_ACCESS;
        PENABLE <= 1'b1;
      end else if (fin) begin
        state   <= ST_IDLE;
        PSEL    <= 1'b0;
        PENABLE <= 1'b0;
      end
    end
endmodule
